// File: rtl/hatch_pkg.sv
// Shared types and constants for the egg-hatch game controller.
package hatch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    HATCHED,
    FAILED
  } state_t;

  localparam int DZ_W   = 5;
  localparam int TIME_W = 6;

  localparam logic [DZ_W-1:0] DZ_HATCHED = 5'd16;

endpackage

// File: rtl/sec_timer.sv
// Game-second timer: a prescaler divides clk down to seconds and a
// down-counter tracks the seconds left in the round.
module sec_timer
  import hatch_pkg::*;
#(
  parameter int CLK_DIV    = 1000,
  parameter int TIME_LIMIT = 30
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              enable,
  output logic [TIME_W-1:0] time_left,
  output logic              expire
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0]     PRE_LAST = PW'(CLK_DIV - 1);
  localparam logic [TIME_W-1:0] TL_INIT  = TIME_W'(TIME_LIMIT);

  logic [PW-1:0] prescaler;
  logic          tick;

  // A second elapses on the prescaler terminal count; the last one ends the round.
  assign tick   = enable && (prescaler == PRE_LAST);
  assign expire = tick && (time_left == TIME_W'(1));

  // Prescaler and seconds counter; load restarts the round, counting only while enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
      time_left <= TL_INIT;
    end else if (load) begin
      prescaler <= '0;
      time_left <= TL_INIT;
    end else if (enable) begin
      if (prescaler == PRE_LAST) begin
        prescaler <= '0;
        if (time_left != '0) begin
          time_left <= time_left - 1'b1;
        end
      end else begin
        prescaler <= prescaler + 1'b1;
      end
    end
  end

endmodule

// File: rtl/hatch_ctrl.sv
// Egg-hatch game controller: turns debounced taps into egg stages,
// runs the round countdown and strobes dst whenever the display must reload.
module hatch_ctrl
  import hatch_pkg::*;
#(
  parameter int CLK_DIV        = 1000,
  parameter int TAPS_PER_STAGE = 4,
  parameter int TIME_LIMIT     = 30
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_start,
  input  logic              btn_tap,
  output logic [DZ_W-1:0]   dz_num,
  output logic              fail,
  output logic              win,
  output logic              dst,
  output logic [TIME_W-1:0] time_left
);

  localparam int CW = $clog2(TAPS_PER_STAGE) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TAPS_PER_STAGE - 1);

  state_t        state;
  logic [CW-1:0] tap_cnt;
  logic          start_ok;
  logic          playing;
  logic          stage_up;
  logic          hatching;
  logic          timer_expire;

  // A start is only honoured outside PLAY; a tap only counts inside PLAY.
  assign playing  = (state == PLAY);
  assign start_ok = btn_start && !playing;
  assign stage_up = playing && btn_tap && (tap_cnt == CNT_LAST);
  assign hatching = stage_up && (dz_num == DZ_HATCHED - 1'b1);

  sec_timer #(
    .CLK_DIV    (CLK_DIV),
    .TIME_LIMIT (TIME_LIMIT)
  ) u_sec_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (start_ok),
    .enable    (playing),
    .time_left (time_left),
    .expire    (timer_expire)
  );

  // Game FSM with tap/stage counting; a hatching tap beats a same-cycle timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      dz_num  <= '0;
      tap_cnt <= '0;
      fail    <= 1'b0;
      win     <= 1'b0;
      dst     <= 1'b0;
    end else begin
      dst <= 1'b0;
      case (state)
        IDLE, HATCHED, FAILED: begin
          if (btn_start) begin
            state   <= PLAY;
            dz_num  <= '0;
            tap_cnt <= '0;
            fail    <= 1'b0;
            win     <= 1'b0;
            dst     <= 1'b1;
          end
        end
        PLAY: begin
          if (hatching) begin
            state   <= HATCHED;
            dz_num  <= DZ_HATCHED;
            tap_cnt <= '0;
            win     <= 1'b1;
            dst     <= 1'b1;
          end else if (timer_expire) begin
            state <= FAILED;
            fail  <= 1'b1;
            dst   <= 1'b1;
          end else if (btn_tap) begin
            if (tap_cnt == CNT_LAST) begin
              tap_cnt <= '0;
              dz_num  <= dz_num + 1'b1;
              dst     <= 1'b1;
            end else begin
              tap_cnt <= tap_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hatch_ctrl.sv
// Directed bench for hatch_ctrl. dut_a uses the short round (CLK_DIV=4, TIME_LIMIT=3)
// for timeout/reset behaviour; dut_b uses CLK_DIV=16 so a full hatch fits in the round.
module tb_hatch_ctrl;

  logic       clk;
  logic       rst_n;
  logic       a_start, a_tap, b_start, b_tap;
  logic [4:0] a_dz, b_dz;
  logic       a_fail, a_win, a_dst, b_fail, b_win, b_dst;
  logic [5:0] a_tl, b_tl;

  int tests_run    = 0;
  int tests_failed = 0;

  hatch_ctrl #(
    .CLK_DIV        (4),
    .TAPS_PER_STAGE (2),
    .TIME_LIMIT     (3)
  ) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_start (a_start),
    .btn_tap   (a_tap),
    .dz_num    (a_dz),
    .fail      (a_fail),
    .win       (a_win),
    .dst       (a_dst),
    .time_left (a_tl)
  );

  hatch_ctrl #(
    .CLK_DIV        (16),
    .TAPS_PER_STAGE (2),
    .TIME_LIMIT     (3)
  ) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_start (b_start),
    .btn_tap   (b_tap),
    .dz_num    (b_dz),
    .fail      (b_fail),
    .win       (b_win),
    .dst       (b_dst),
    .time_left (b_tl)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hold the buttons for one clock edge, then sample 1 time unit after that edge.
  task automatic applyStimulus(input logic sa, input logic ta, input logic sb, input logic tb2);
    a_start = sa;
    a_tap   = ta;
    b_start = sb;
    b_tap   = tb2;
    @(posedge clk);
    #1;
    a_start = 1'b0;
    a_tap   = 1'b0;
    b_start = 1'b0;
    b_tap   = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    a_start = 1'b0;
    a_tap   = 1'b0;
    b_start = 1'b0;
    b_tap   = 1'b0;
    #12;
    checkOutput("rst_dz",   32'(a_dz),   32'd0);
    checkOutput("rst_tl",   32'(a_tl),   32'd3);
    checkOutput("rst_fail", 32'(a_fail), 32'd0);
    checkOutput("rst_win",  32'(a_win),  32'd0);
    checkOutput("rst_dst",  32'(a_dst),  32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Start round on dut_a
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("start_dz",   32'(a_dz),   32'd0);
    checkOutput("start_tl",   32'(a_tl),   32'd3);
    checkOutput("start_dst",  32'(a_dst),  32'd1);
    checkOutput("start_fail", 32'(a_fail), 32'd0);
    // Two taps advance one stage, dst only on the second
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("tap1_dz",  32'(a_dz),  32'd0);
    checkOutput("tap1_dst", 32'(a_dst), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("tap2_dz",  32'(a_dz),  32'd1);
    checkOutput("tap2_dst", 32'(a_dst), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("e3_dst", 32'(a_dst), 32'd0);
    checkOutput("e3_tl",  32'(a_tl),  32'd3);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("e4_tl", 32'(a_tl), 32'd2);
    idleCycles(6);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("e11_tl",   32'(a_tl),   32'd1);
    checkOutput("e11_fail", 32'(a_fail), 32'd0);
    // Timeout at 12 cycles after start
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("tout_tl",   32'(a_tl),   32'd0);
    checkOutput("tout_fail", 32'(a_fail), 32'd1);
    checkOutput("tout_dst",  32'(a_dst),  32'd1);
    checkOutput("tout_dz",   32'(a_dz),   32'd1);
    // Taps in FAILED are ignored and nothing moves
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("failed_dst",  32'(a_dst),  32'd0);
    checkOutput("failed_dz",   32'(a_dz),   32'd1);
    checkOutput("failed_fail", 32'(a_fail), 32'd1);
    checkOutput("failed_tl",   32'(a_tl),   32'd0);
    // Restart from FAILED with a simultaneous tap
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("restart_dz",   32'(a_dz),   32'd0);
    checkOutput("restart_fail", 32'(a_fail), 32'd0);
    checkOutput("restart_tl",   32'(a_tl),   32'd3);
    checkOutput("restart_dst",  32'(a_dst),  32'd1);
    // Ten taps reach stage 5
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("mid_dz", 32'(a_dz), 32'd5);
    checkOutput("mid_tl", 32'(a_tl), 32'd1);
    // Asynchronous reset between clock edges
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_dz",   32'(a_dz),   32'd0);
    checkOutput("arst_tl",   32'(a_tl),   32'd3);
    checkOutput("arst_dst",  32'(a_dst),  32'd0);
    checkOutput("arst_fail", 32'(a_fail), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // Back in IDLE: taps ignored, timer frozen
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("idle_dz",  32'(a_dz),  32'd0);
    checkOutput("idle_dst", 32'(a_dst), 32'd0);
    idleCycles(5);
    checkOutput("idle_tl", 32'(a_tl), 32'd3);

    // dut_b: full hatch
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("b_start_dst", 32'(b_dst), 32'd1);
    checkOutput("b_start_dz",  32'(b_dz),  32'd0);
    for (int i = 1; i <= 32; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      if (i == 31) begin
        checkOutput("b_pre_dz",  32'(b_dz),  32'd15);
        checkOutput("b_pre_win", 32'(b_win), 32'd0);
      end
    end
    checkOutput("hatch_dz",   32'(b_dz),   32'd16);
    checkOutput("hatch_win",  32'(b_win),  32'd1);
    checkOutput("hatch_dst",  32'(b_dst),  32'd1);
    checkOutput("hatch_fail", 32'(b_fail), 32'd0);
    checkOutput("hatch_tl",   32'(b_tl),   32'd1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("post_dz",  32'(b_dz),  32'd16);
    checkOutput("post_dst", 32'(b_dst), 32'd0);
    idleCycles(20);
    checkOutput("post_tl",   32'(b_tl),   32'd1);
    checkOutput("post_fail", 32'(b_fail), 32'd0);
    checkOutput("post_win",  32'(b_win),  32'd1);

    // dut_b: hatch on the same cycle as the final-second timeout
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("b_re_win", 32'(b_win), 32'd0);
    checkOutput("b_re_dz",  32'(b_dz),  32'd0);
    checkOutput("b_re_tl",  32'(b_tl),  32'd3);
    idleCycles(16);
    checkOutput("b_e16_tl", 32'(b_tl), 32'd2);
    for (int i = 1; i <= 32; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      if (i == 31) begin
        checkOutput("race_pre_dz",   32'(b_dz),   32'd15);
        checkOutput("race_pre_tl",   32'(b_tl),   32'd1);
        checkOutput("race_pre_fail", 32'(b_fail), 32'd0);
      end
    end
    checkOutput("race_win",  32'(b_win),  32'd1);
    checkOutput("race_fail", 32'(b_fail), 32'd0);
    checkOutput("race_dz",   32'(b_dz),   32'd16);
    checkOutput("race_dst",  32'(b_dst),  32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
